// File: rtl/lowampa_coeff_sequencer.sv
// lowampa_coeff_sequencer: shadow/live coefficient banks with commit, DSP flush and settle sequencing
// Ports: clk_i/rst_ni clock and async active-low reset; wr_* shadow write handshake;
// commit_i applies shadow to live coeff_o; dsp_rst_o flushes the chain; filt_valid_o marks
// settled output; busy_o high during FLUSH/SETTLE; err_o sticky out-of-range write flag.
// Optional LOWAMPA_COEFF_READBACK_EN adds rd_addr_i/rd_sel_i/rd_data_o registered readback.
module lowampa_coeff_sequencer #(
  parameter int NTAPS      = 8,
  parameter int COEFF_W    = 18,
  parameter int FLUSH_CYC  = 2,
  parameter int SETTLE_CYC = 10
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_valid_i,
  output logic                       wr_ready_o,
  input  logic [$clog2(NTAPS)-1:0]   wr_addr_i,
  input  logic [COEFF_W-1:0]         wr_data_i,
  input  logic                       commit_i,
  output logic [NTAPS*COEFF_W-1:0]   coeff_o,
  output logic                       dsp_rst_o,
  output logic                       filt_valid_o,
  output logic                       busy_o,
`ifdef LOWAMPA_COEFF_READBACK_EN
  output logic                       err_o,
  input  logic [$clog2(NTAPS)-1:0]   rd_addr_i,
  input  logic                       rd_sel_i,
  output logic [COEFF_W-1:0]         rd_data_o
`else
  output logic                       err_o
`endif
);
  typedef enum logic [1:0] {IDLE, FLUSH, SETTLE} state_t;
  localparam logic [5:0] F_LD = 6'(FLUSH_CYC - 1);
  localparam logic [5:0] S_LD = 6'(SETTLE_CYC == 0 ? 0 : SETTLE_CYC - 1);
  state_t state, state_n;
  logic [5:0] cnt, cnt_n;
  logic valid_n, wr_acc, wr_in, commit_go;
  logic [COEFF_W-1:0] shadow [NTAPS];
  // wr_ready_o is only high in IDLE, so an accepted write implies IDLE
  assign wr_acc    = wr_valid_i & wr_ready_o;
  assign wr_in     = int'(wr_addr_i) < NTAPS;
  assign commit_go = (state == IDLE) & commit_i;
  always_comb begin
    state_n = state;
    cnt_n   = cnt - 6'd1;
    valid_n = filt_valid_o;
    case (state)
      IDLE: begin
        cnt_n = F_LD;
        if (commit_i) begin
          state_n = FLUSH;
          valid_n = 1'b0;
        end
      end
      FLUSH: if (cnt == 6'd0) begin
        state_n = SETTLE_CYC == 0 ? IDLE : SETTLE;
        cnt_n   = S_LD;
        valid_n = SETTLE_CYC == 0;
      end
      SETTLE: if (cnt == 6'd0) begin
        state_n = IDLE;
        valid_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  // outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_ready_o   <= 1'b0;
      dsp_rst_o    <= 1'b0;
      busy_o       <= 1'b0;
      filt_valid_o <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      wr_ready_o   <= state_n == IDLE;
      dsp_rst_o    <= state_n == FLUSH;
      busy_o       <= state_n != IDLE;
      filt_valid_o <= valid_n;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NTAPS; k++) shadow[k] <= '0;
      coeff_o <= '0;
      err_o   <= 1'b0;
    end else begin
      if (wr_acc && wr_in) shadow[wr_addr_i] <= wr_data_i;
      // a write in the commit cycle is merged into the live bank
      if (commit_go)
        for (int k = 0; k < NTAPS; k++)
          coeff_o[k*COEFF_W +: COEFF_W] <= (wr_acc && wr_in && int'(wr_addr_i) == k) ? wr_data_i : shadow[k];
      err_o <= (wr_acc && !wr_in) | (err_o & ~commit_go);
    end
  end
`ifdef LOWAMPA_COEFF_READBACK_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rd_data_o <= '0;
    else rd_data_o <= int'(rd_addr_i) >= NTAPS ? '0 :
                      rd_sel_i ? coeff_o[int'(rd_addr_i)*COEFF_W +: COEFF_W] : shadow[rd_addr_i];
  end
`endif
endmodule

// File: tb/tb_lowampa_coeff_sequencer.sv
// tb_lowampa_coeff_sequencer: randomized and directed checks against a timeline-based reference model
module tb_lowampa_coeff_sequencer;
  localparam int NA = 6, NB = 8, W = 18, FA = 2, SA = 10, FB = 1, SB = 0;
  logic clk = 0, rst_n = 0, wr_valid = 0, commit = 0;
  logic [2:0] wr_addr = 0;
  logic [W-1:0] wr_data = 0;
  logic a_ready, a_dsp_rst, a_valid, a_busy, a_err;
  logic b_ready, b_dsp_rst, b_valid, b_busy, b_err;
  logic [NA*W-1:0] a_coeff;
  logic [NB*W-1:0] b_coeff;
  int n_cmp = 0, n_bad = 0;
  logic [W-1:0] sh [NA];
  logic [W-1:0] live [NA];
  bit err_m, rdy_a, rdy_b;
  int ca, cb;
  always #5 clk = ~clk;
  lowampa_coeff_sequencer #(.NTAPS(NA), .COEFF_W(W), .FLUSH_CYC(FA), .SETTLE_CYC(SA)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(a_ready),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .commit_i(commit), .coeff_o(a_coeff),
    .dsp_rst_o(a_dsp_rst), .filt_valid_o(a_valid), .busy_o(a_busy), .err_o(a_err));
  lowampa_coeff_sequencer #(.NTAPS(NB), .COEFF_W(W), .FLUSH_CYC(FB), .SETTLE_CYC(SB)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(b_ready),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .commit_i(commit), .coeff_o(b_coeff),
    .dsp_rst_o(b_dsp_rst), .filt_valid_o(b_valid), .busy_o(b_busy), .err_o(b_err));
  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // c = cycles since the accepted commit edge (0 = never committed); idle once c exceeds flush+settle
  function automatic bit idle(input int c, input int tot);
    return c == 0 || c > tot;
  endfunction
  function automatic int adv(input int c, input int tot, input bit cm);
    if (idle(c, tot) && cm) return 1;
    if (c == 0 || c > tot) return c;
    return c + 1;
  endfunction
  function automatic logic [NA*W-1:0] live_vec();
    logic [NA*W-1:0] v;
    for (int k = 0; k < NA; k++) v[k*W +: W] = live[k];
    return v;
  endfunction
  task automatic model_reset();
    for (int k = 0; k < NA; k++) begin
      sh[k] = '0;
      live[k] = '0;
    end
    err_m = 0; rdy_a = 0; rdy_b = 0; ca = 0; cb = 0;
  endtask
  task automatic model_edge();
    bit acc, inr, go;
    if (!rst_n) model_reset();
    else begin
      acc = wr_valid && rdy_a;
      inr = int'(wr_addr) < NA;
      go  = commit && idle(ca, FA + SA);
      if (acc && inr) sh[wr_addr] = wr_data;
      if (go) for (int k = 0; k < NA; k++) live[k] = sh[k];
      if (acc && !inr) err_m = 1;
      else if (go) err_m = 0;
      ca = adv(ca, FA + SA, commit);
      cb = adv(cb, FB + SB, commit);
      rdy_a = idle(ca, FA + SA);
      rdy_b = idle(cb, FB + SB);
    end
  endtask
  task automatic compare();
    check("a_coeff", a_coeff, live_vec());
    check("a_dsp_rst", a_dsp_rst, ca >= 1 && ca <= FA);
    check("a_busy", a_busy, ca >= 1 && ca <= FA + SA);
    check("a_valid", a_valid, ca > FA + SA);
    check("a_ready", a_ready, rdy_a);
    check("a_err", a_err, err_m);
    check("b_dsp_rst", b_dsp_rst, cb >= 1 && cb <= FB);
    check("b_busy", b_busy, cb >= 1 && cb <= FB + SB);
    check("b_valid", b_valid, cb > FB + SB);
    check("b_ready", b_ready, rdy_b);
    check("b_err", b_err, 0);
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask
  // commit, optionally re-pulse commit at cycles p1/p2, and measure latency and flush pulse length
  task automatic run_commit(input string tag, input int p1, input int p2);
    int n, rst_cyc;
    commit = 1;
    step();
    commit = 0;
    wr_valid = 0;
    n = 1;
    rst_cyc = a_dsp_rst;
    while (!a_valid && n < 40) begin
      commit = (n == p1 || n == p2);
      step();
      commit = 0;
      n++;
      rst_cyc += a_dsp_rst;
    end
    check({tag, "_latency"}, n, 1 + FA + SA);
    check({tag, "_flush_len"}, rst_cyc, FA);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int i;
    bit r;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    rst_n = 1;
    step();
    for (int t = 0; t < NA; t++) begin
      wr_valid = 1; wr_addr = 3'(t); wr_data = W'(t + 1);
      step();
    end
    wr_valid = 0;
    check("pre_commit_coeff", a_coeff, 0);
    run_commit("basic", -1, -1);
    check("basic_tap5", a_coeff[5*W +: W], 6);
    repeat (2) step();
    wr_valid = 1; wr_addr = 3; wr_data = 18'h3FFFB;
    run_commit("merge", -1, -1);
    check("merge_tap3", a_coeff[3*W +: W], 18'h3FFFB);
    check("merge_tap0", a_coeff[0 +: W], 1);
    step();
    run_commit("ignore", 1, 5);
    commit = 1;
    step();
    commit = 0;
    repeat (4) step();
    wr_valid = 1; wr_addr = 2; wr_data = 7;
    for (i = 0; i < 30; i++) begin
      r = a_ready;
      step();
      if (r) break;
    end
    wr_valid = 0;
    check("stall_wait", i, FA + SA + 1 - 5);
    check("stall_live_tap2", a_coeff[2*W +: W], 3);
    run_commit("stall_commit", -1, -1);
    check("new_tap2", a_coeff[2*W +: W], 7);
    wr_valid = 1; wr_addr = 6; wr_data = 99;
    step();
    wr_valid = 0;
    check("err_set", a_err, 1);
    run_commit("err_clear", -1, -1);
    check("err_cleared", a_err, 0);
    wr_valid = 1; wr_addr = 7; wr_data = 55;
    run_commit("err_merge", -1, -1);
    check("err_merge_kept", a_err, 1);
    commit = 1;
    step();
    commit = 0;
    step();
    #3;
    rst_n = 0;
    #1;
    check("arst_coeff", a_coeff, 0);
    check("arst_dsp_rst", a_dsp_rst, 0);
    check("arst_valid", a_valid, 0);
    check("arst_busy", a_busy, 0);
    check("arst_ready", a_ready, 0);
    check("arst_err", a_err, 0);
    step();
    rst_n = 1;
    repeat (3) step();
    repeat (600) begin
      rst_n    = $urandom_range(0, 199) != 0;
      wr_valid = $urandom_range(0, 1) == 1;
      wr_addr  = 3'($urandom_range(0, 7));
      wr_data  = W'($urandom);
      commit   = $urandom_range(0, 7) == 0;
      step();
    end
    rst_n = 1; wr_valid = 0; commit = 0;
    repeat (20) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
